// File: rtl/tea_pkg.sv
// Shared TEA definitions: round constant, initial decrypt sum and FSM state encoding.
package tea_pkg;

    localparam logic [31:0] DELTA = 32'h9E3779B9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tea_state_t;

    // Decryption starts from the sum encryption ended with: DELTA*nrounds mod 2^32.
    function automatic logic [31:0] SUM_INIT(input int unsigned nrounds);
        return DELTA * nrounds[31:0];
    endfunction

endpackage

// File: rtl/tea_dec_round.sv
// One combinational TEA decryption cycle: undo v1, then v0 using the new v1, then step sum back.
module tea_dec_round
    import tea_pkg::*;
(
    input  logic [31:0] v0,
    input  logic [31:0] v1,
    input  logic [31:0] sum,
    input  logic [31:0] k0,
    input  logic [31:0] k1,
    input  logic [31:0] k2,
    input  logic [31:0] k3,
    output logic [31:0] v0_next,
    output logic [31:0] v1_next,
    output logic [31:0] sum_next
);

    assign v1_next  = v1 - (((v0 << 4) + k2) ^ (v0 + sum) ^ ((v0 >> 5) + k3));
    assign v0_next  = v0 - (((v1_next << 4) + k0) ^ (v1_next + sum) ^ ((v1_next >> 5) + k1));
    assign sum_next = sum - DELTA;

endmodule

// File: rtl/tea_decrypt_core.sv
// Iterative TEA block decryptor with valid/ready handshakes on both sides.
// Define TEA_DEC_UNROLL2_EN to chain two round instances and halve the RUN time.
module tea_decrypt_core
    import tea_pkg::*;
#(
    parameter int NROUNDS = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [63:0]  din,
    input  logic [127:0] dinKey,
    input  logic         di_vld,
    output logic         di_rdy,
    output logic [63:0]  dout,
    output logic         do_vld,
    input  logic         do_rdy
);

`ifdef TEA_DEC_UNROLL2_EN
    localparam int RUN_CLKS = NROUNDS / 2;
`else
    localparam int RUN_CLKS = NROUNDS;
`endif
    localparam logic [6:0] CNT_LAST = 7'(RUN_CLKS - 1);

    tea_state_t    state_reg, state_next;
    logic          rdy_en_reg;
    logic [6:0]    cnt_reg;
    logic [31:0]   v0_reg, v1_reg, sum_reg;
    logic [127:0]  key_reg;
    logic [63:0]   dout_reg;
    logic          load, run;

    logic [31:0]   r0_v0, r0_v1, r0_sum;
    logic [31:0]   step_v0, step_v1, step_sum;

    tea_dec_round u_round0 (
        .v0       (v0_reg),
        .v1       (v1_reg),
        .sum      (sum_reg),
        .k0       (key_reg[127:96]),
        .k1       (key_reg[95:64]),
        .k2       (key_reg[63:32]),
        .k3       (key_reg[31:0]),
        .v0_next  (r0_v0),
        .v1_next  (r0_v1),
        .sum_next (r0_sum)
    );

`ifdef TEA_DEC_UNROLL2_EN
    tea_dec_round u_round1 (
        .v0       (r0_v0),
        .v1       (r0_v1),
        .sum      (r0_sum),
        .k0       (key_reg[127:96]),
        .k1       (key_reg[95:64]),
        .k2       (key_reg[63:32]),
        .k3       (key_reg[31:0]),
        .v0_next  (step_v0),
        .v1_next  (step_v1),
        .sum_next (step_sum)
    );
`else
    assign step_v0  = r0_v0;
    assign step_v1  = r0_v1;
    assign step_sum = r0_sum;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        di_rdy     = 1'b0;
        do_vld     = 1'b0;
        load       = 1'b0;
        run        = 1'b0;
        case (state_reg)
            IDLE: begin
                // rdy_en_reg keeps di_rdy low until the first edge after reset release
                di_rdy = rdy_en_reg;
                if (rdy_en_reg && di_vld) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                run = 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                do_vld = 1'b1;
                if (do_rdy) begin
                    di_rdy     = 1'b1;
                    state_next = IDLE;
                    if (di_vld) begin
                        load       = 1'b1;
                        state_next = RUN;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rdy_en_reg <= 1'b0;
            cnt_reg    <= '0;
            v0_reg     <= '0;
            v1_reg     <= '0;
            sum_reg    <= '0;
            key_reg    <= '0;
            dout_reg   <= '0;
        end else begin
            rdy_en_reg <= 1'b1;
            if (load) begin
                v0_reg  <= din[63:32];
                v1_reg  <= din[31:0];
                key_reg <= dinKey;
                sum_reg <= SUM_INIT(NROUNDS);
                cnt_reg <= '0;
            end else if (run) begin
                v0_reg  <= step_v0;
                v1_reg  <= step_v1;
                sum_reg <= step_sum;
                cnt_reg <= cnt_reg + 7'd1;
                // Only the finished block reaches dout; working state never does.
                if (cnt_reg == CNT_LAST) begin
                    dout_reg <= {step_v0, step_v1};
                end
            end
        end
    end

    assign dout = dout_reg;

endmodule

// File: tb/tb_tea_decrypt_core.sv
// Randomized self-checking bench for tea_decrypt_core against a plain TEA model.
module tb_tea_decrypt_core;

    localparam int NR = 32;
`ifdef TEA_DEC_UNROLL2_EN
    localparam int LAT = NR / 2 + 1;
`else
    localparam int LAT = NR + 1;
`endif
    localparam logic [31:0] TB_DELTA = 32'h9E3779B9;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic [63:0]  din = '0;
    logic [127:0] dinKey = '0;
    logic         di_vld = 1'b0;
    logic         di_rdy;
    logic [63:0]  dout;
    logic         do_vld;
    logic         do_rdy = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [63:0] exp_q[$];
    int          acc_q[$];
    logic [63:0] last_out = '0;
    logic [63:0] held_dout = '0;
    logic        prev_held = 1'b0;

    tea_decrypt_core #(.NROUNDS(NR)) dut (
        .clk    (clk),
        .clr    (clr),
        .din    (din),
        .dinKey (dinKey),
        .di_vld (di_vld),
        .di_rdy (di_rdy),
        .dout   (dout),
        .do_vld (do_vld),
        .do_rdy (do_rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] tea_enc(input logic [63:0] p, input logic [127:0] k);
        logic [31:0] a, b, s;
        a = p[63:32];
        b = p[31:0];
        s = 32'h0;
        for (int i = 0; i < NR; i++) begin
            s = s + TB_DELTA;
            a = a + (((b << 4) + k[127:96]) ^ (b + s) ^ ((b >> 5) + k[95:64]));
            b = b + (((a << 4) + k[63:32]) ^ (a + s) ^ ((a >> 5) + k[31:0]));
        end
        return {a, b};
    endfunction

    function automatic logic [63:0] tea_dec(input logic [63:0] c, input logic [127:0] k);
        logic [31:0] a, b, s;
        a = c[63:32];
        b = c[31:0];
        s = TB_DELTA * NR;
        for (int i = 0; i < NR; i++) begin
            b = b - (((a << 4) + k[63:32]) ^ (a + s) ^ ((a >> 5) + k[31:0]));
            a = a - (((b << 4) + k[127:96]) ^ (b + s) ^ ((b >> 5) + k[95:64]));
            s = s - TB_DELTA;
        end
        return {a, b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard: every accepted block must emerge exactly LAT clocks later, held stable until taken.
    always @(negedge clk) begin
        if (clr) begin
            exp_q.delete();
            acc_q.delete();
            prev_held = 1'b0;
        end else begin
            if (do_vld) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_do_vld", 64'(do_vld), 64'd0);
                end else if (!prev_held) begin
                    chk("latency", 64'(cyc - acc_q[0]), 64'(LAT));
                    chk("dout", dout, exp_q[0]);
                end else begin
                    chk("dout_stable", dout, held_dout);
                end
                if (!do_rdy) chk("di_rdy_in_stall", 64'(di_rdy), 64'd0);
            end else if (exp_q.size() > 0) begin
                chk("di_rdy_in_run", 64'(di_rdy), 64'd0);
            end
            prev_held = do_vld && !do_rdy;
            held_dout = dout;
            if (do_vld && do_rdy && exp_q.size() > 0) begin
                last_out = exp_q.pop_front();
                void'(acc_q.pop_front());
                $display("result %h at cycle %0d", dout, cyc);
            end
            if (di_vld && di_rdy) begin
                exp_q.push_back(tea_dec(din, dinKey));
                acc_q.push_back(cyc);
                $display("accept din=%h key=%h at cycle %0d", din, dinKey, cyc);
            end
        end
    end

    task automatic send(input logic [63:0] d, input logic [127:0] k);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        din = d;
        dinKey = k;
        di_vld = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = di_rdy;
            if (!ok) begin @(posedge clk); #1; end
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        di_vld = 1'b0;
        din = {$urandom, $urandom};
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0);
        end
        if (!done) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic [63:0]  ct, pt;
        logic [127:0] key;
        int           acc_cyc[4];
        int           nacc;
        bit           ok;

        // Model pinned to the published all-zero TEA vector.
        chk("model_enc_kat", tea_enc(64'h0, 128'h0), 64'h41EA3A0A94BAA940);
        chk("model_dec_kat", tea_dec(64'h41EA3A0A94BAA940, 128'h0), 64'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", dout, 64'h0);
        chk("rst_do_vld", 64'(do_vld), 64'd0);
        chk("rst_di_rdy", 64'(di_rdy), 64'd0);
        clr = 1'b0;
        @(negedge clk);
        chk("di_rdy_before_edge", 64'(di_rdy), 64'd0);
        @(negedge clk);
        chk("di_rdy_after_edge", 64'(di_rdy), 64'd1);

        // Known answer with dinKey and di_vld scrambled during RUN.
        send(64'h41EA3A0A94BAA940, 128'h0);
        for (int i = 0; i < 10; i++) begin
            dinKey = {$urandom, $urandom, $urandom, $urandom};
            di_vld = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        di_vld = 1'b0;
        drain();
        chk("kat_plain", last_out, 64'h0);

        // Round trip through the model's encryptor.
        key = 128'h00112233445566778899AABBCCDDEEFF;
        ct = tea_enc(64'h0123456789ABCDEF, key);
        send(ct, key);
        drain();
        chk("round_trip", last_out, 64'h0123456789ABCDEF);

        // Back-pressure: hold DONE for 10 clocks, then take result and accept a new block together.
        do_rdy = 1'b0;
        send({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = do_vld;
        end
        if (!ok) chk("bp_timeout", 64'd0, 64'd1);
        repeat (10) @(posedge clk);
        #1;
        din = {$urandom, $urandom};
        dinKey = {$urandom, $urandom, $urandom, $urandom};
        di_vld = 1'b1;
        do_rdy = 1'b1;
        @(negedge clk);
        chk("bp_accept_rdy", 64'(di_rdy), 64'd1);
        @(posedge clk); #1;
        di_vld = 1'b0;
        drain();

        // Reset at round 15 aborts the block; a fresh block afterwards must decrypt.
        send({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        repeat (14) @(posedge clk);
        #3;
        clr = 1'b1;
        #1;
        chk("abort_do_vld", 64'(do_vld), 64'd0);
        chk("abort_dout", dout, 64'h0);
        chk("abort_di_rdy", 64'(di_rdy), 64'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_idle_rdy", 64'(di_rdy), 64'd1);
        key = {$urandom, $urandom, $urandom, $urandom};
        pt = {$urandom, $urandom};
        send(tea_enc(pt, key), key);
        drain();
        chk("after_abort", last_out, pt);

        // Back-to-back: di_vld held high, four acceptances spaced LAT apart.
        nacc = 0;
        @(posedge clk); #1;
        din = {$urandom, $urandom};
        dinKey = {$urandom, $urandom, $urandom, $urandom};
        di_vld = 1'b1;
        for (int i = 0; i < 400 && nacc < 4; i++) begin
            @(negedge clk);
            ok = di_rdy;
            if (ok) begin
                acc_cyc[nacc] = cyc;
                nacc++;
            end
            @(posedge clk); #1;
            if (ok) begin
                din = {$urandom, $urandom};
                dinKey = {$urandom, $urandom, $urandom, $urandom};
                if (nacc == 4) di_vld = 1'b0;
            end
        end
        di_vld = 1'b0;
        if (nacc < 4) chk("b2b_timeout", 64'(nacc), 64'd4);
        else for (int i = 1; i < 4; i++) chk("b2b_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(LAT));
        drain();

        // Random traffic with random consumer stalls and input gaps.
        for (int b = 0; b < 20; b++) begin
            din = {$urandom, $urandom};
            dinKey = {$urandom, $urandom, $urandom, $urandom};
            di_vld = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 500 && !ok; i++) begin
                do_rdy = 1'($urandom_range(0, 1));
                @(negedge clk);
                ok = di_rdy;
                @(posedge clk); #1;
            end
            if (!ok) chk("rand_timeout", 64'd0, 64'd1);
            di_vld = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                do_rdy = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        do_rdy = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
